// File: rtl/alarm_msg_arbiter.sv
// Arbitrates alarm channels onto one message sender: latches alarm rising edges, grants one at a time,
// waits for tx_done (or a timeout), then holds off. Define ALARM_ARB_RR_EN for round-robin arbitration.

module alarm_ch_cell (
  input  logic clk,
  input  logic rst,
  input  logic alarm_in,
  input  logic grant,
  input  logic requeue,
  output logic pending
);
  logic alarm_d_q, seen_low_q, pend_q;
  logic alarm_d_d, seen_low_d, pend_d, rise;

  // A level already high when reset releases must drop before it can request.
  assign rise = alarm_in & ~alarm_d_q & seen_low_q;

  always_comb begin
    alarm_d_d  = alarm_in;
    seen_low_d = seen_low_q | ~alarm_in;
    pend_d     = pend_q;
    if (grant)   pend_d = 1'b0;
    if (requeue) pend_d = 1'b1;
    if (rise)    pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_d_q  <= 1'b0;
      seen_low_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      alarm_d_q  <= alarm_d_d;
      seen_low_q <= seen_low_d;
      pend_q     <= pend_d;
    end
  end

  assign pending = pend_q;
endmodule

module alarm_msg_arbiter #(
  parameter int N_CH        = 4,
  parameter int ID_W        = 3,
  parameter int HOLDOFF_CYC = 50_000_000,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] alarm_in,
  input  logic            tx_busy,
  input  logic            tx_done,
  output logic            tx_start,
  output logic [ID_W-1:0] tx_msg_id,
  output logic [N_CH-1:0] pending,
  output logic            tx_timeout
);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, HOLDOFF} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  gnt_q, gnt_d, sel;
  logic             grant_ev, requeue_ev;
  logic [N_CH-1:0]  gnt_vec, rq_vec;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign gnt_vec[i] = grant_ev   && (gnt_q == ID_W'(i));
    assign rq_vec[i]  = requeue_ev && (gnt_q == ID_W'(i));
    alarm_ch_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .alarm_in (alarm_in[i]),
      .grant    (gnt_vec[i]),
      .requeue  (rq_vec[i]),
      .pending  (pending[i])
    );
  end

`ifdef ALARM_ARB_RR_EN
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] sel_lo, sel_hi;
  logic            any_hi;

  // Lowest pending index above last grant, else wrap to the lowest pending index.
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    any_hi = 1'b0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_lo = ID_W'(i);
        if (ID_W'(i) > last_q) begin
          sel_hi = ID_W'(i);
          any_hi = 1'b1;
        end
      end
    end
    sel = any_hi ? sel_hi : sel_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= ID_W'(N_CH-1);
    else     last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == START) last_d = gnt_q;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = N_CH-1; i >= 0; i--)
      if (pending[i]) sel = ID_W'(i);
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    tx_start   = 1'b0;
    tx_timeout = 1'b0;
    grant_ev   = 1'b0;
    requeue_ev = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|pending) && !tx_busy) begin
          gnt_d   = sel;
          state_d = START;
        end
      end
      START: begin
        tx_start = 1'b1;
        grant_ev = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        // tx_done wins over a coincident expiry.
        if (tx_done) begin
          cnt_d   = '0;
          state_d = HOLDOFF;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC-1)) begin
          tx_timeout = 1'b1;
          requeue_ev = 1'b1;
          cnt_d      = '0;
          state_d    = HOLDOFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYC-1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign tx_msg_id = gnt_q;
endmodule

// File: tb/tb_alarm_msg_arbiter.sv
// Randomized scoreboard bench for alarm_msg_arbiter: a cycle-timeline reference model predicts
// start/timeout events and pending bits; a negedge monitor compares them against the DUT.
module tb_alarm_msg_arbiter;
  localparam int N = 4, IDW = 3, HO = 4, TO = 8, CW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   alarm_in = '0;
  logic           tx_busy = 1'b0, tx_done = 1'b0;
  logic           tx_start, tx_timeout;
  logic [IDW-1:0] tx_msg_id;
  logic [N-1:0]   pending;

  alarm_msg_arbiter #(.N_CH(N), .ID_W(IDW), .HOLDOFF_CYC(HO), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .alarm_in(alarm_in), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_start(tx_start), .tx_msg_id(tx_msg_id), .pending(pending), .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int id; int at; } ev_t;  // kind 0 = start, 1 = timeout
  ev_t expq[$];
  int checks = 0, failures = 0;

  // Reference model: arbiter timeline as cycle numbers.
  logic [N-1:0] m_pend, m_prev, exp_pend;
  bit m_act;
  int m_g, m_tstart, m_tidle, m_last;
  // Sender model
  bit s_infl;
  int s_done_at;
  int lat_cfg = 3;      // -1 random, 0 never acknowledges, >0 fixed latency
  int ext_busy_pct = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int choose(input logic [N-1:0] p, input int last);
`ifdef ALARM_ARB_RR_EN
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (last + 1 + k) % N;
      if (p[idx]) return idx;
    end
`else
    for (int k = 0; k < N; k++) if (p[k]) return k;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_prev = '1; exp_pend = '0;
    m_act = 0; m_tidle = 0; m_last = N-1; m_g = 0; m_tstart = 0;
    s_infl = 0; s_done_at = -1;
    expq.delete();
  endtask

  task automatic step(input logic [N-1:0] a);
    int c, lat;
    logic [N-1:0] rise, clr, rq;
    @(posedge clk); #1;
    rst = 1'b0;
    c = cyc;
    alarm_in = a;
    tx_done  = s_infl && (c == s_done_at);
    tx_busy  = s_infl || ($urandom_range(99) < ext_busy_pct);
    exp_pend = m_pend;
    rise = a & ~m_prev;
    m_prev = a;
    clr = '0; rq = '0;
    if (s_infl && c == s_done_at) s_infl = 0;
    if (m_act && c == m_tstart) begin
      expq.push_back(ev_t'{0, m_g, c});
      clr[m_g] = 1'b1;
      m_last = m_g;
      lat = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(12));
      s_infl = 1;
      s_done_at = (lat == 0) ? -1 : c + lat;
    end else if (m_act && c > m_tstart) begin
      if (tx_done) begin
        m_act = 0; m_tidle = c + 1 + HO;
      end else if (c == m_tstart + TO) begin
        expq.push_back(ev_t'{1, m_g, c});
        rq[m_g] = 1'b1;
        m_act = 0; m_tidle = c + 1 + HO;
        if (s_done_at < 0) s_infl = 0;
      end
    end
    if (!m_act && c >= m_tidle && m_pend != '0 && !tx_busy) begin
      m_g = choose(m_pend, m_last);
      m_tstart = c + 1;
      m_act = 1;
    end
    m_pend = (m_pend & ~clr) | rise | rq;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 300 && (m_act || cyc < m_tidle || m_pend != '0 || s_infl)) begin
      step('0);
      n++;
    end
    check("drain_bound", (n < 300) ? 1 : 0, 1);
    repeat (2) step('0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (expq.size() > 0 && expq[0].at < cyc) begin
        ev_t e;
        e = expq.pop_front();
        check(e.kind == 0 ? "missing_start" : "missing_timeout", 0, 1);
      end
      if (tx_start || tx_timeout) begin
        if (expq.size() == 0) begin
          check(tx_start ? "unexpected_start" : "unexpected_timeout", 1, 0);
        end else begin
          ev_t e;
          e = expq.pop_front();
          check("event_kind", tx_start ? 0 : (tx_timeout ? 1 : 2), e.kind);
          check("event_both", int'(tx_start && tx_timeout), 0);
          check("event_id", int'(tx_msg_id), e.id);
          check("event_cycle", cyc, e.at);
        end
      end
      check("pending", int'(pending), int'(exp_pend));
    end
  end

  initial begin
    int n;
    logic [N-1:0] a;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_timeout", int'(tx_timeout), 0);
    check("rst_tx_msg_id", int'(tx_msg_id), 0);
    check("rst_pending", int'(pending), 0);

    // 1: single held level, acked after 3 cycles
    lat_cfg = 3;
    repeat (2) step('0);
    repeat (30) step(4'b0100);
    drain();
    // 2: simultaneous rise on bits 3 and 1
    repeat (25) step(4'b1010);
    drain();
    // 3: sender never acknowledges -> repeated timeout and re-grant
    lat_cfg = 0;
    repeat (45) step(4'b0001);
    step('0);
    lat_cfg = 3;
    drain();
    // 4: bit 0 rises again in its own START cycle
    step(4'b0001); step(4'b0000); step(4'b0001);
    drain();
    // 5: bits 0 and 1 re-pulsed continuously
    lat_cfg = 2;
    for (int k = 0; k < 40; k++) begin
      step(4'b0011);
      step(4'b0000);
    end
    drain();
    // 6: reset while waiting for tx_done
    lat_cfg = 0;
    n = 0;
    step(4'b0100);
    while (n < 20 && !(m_act && cyc > m_tstart + 1)) begin
      step(4'b0100);
      n++;
    end
    check("reach_wait_done", (n < 20) ? 1 : 0, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx_start", int'(tx_start), 0);
    check("midrst_tx_timeout", int'(tx_timeout), 0);
    check("midrst_tx_msg_id", int'(tx_msg_id), 0);
    check("midrst_pending", int'(pending), 0);
    model_reset();
    repeat (2) @(posedge clk);
    lat_cfg = 3;
    repeat (20) step(4'b0100);
    step('0);
    repeat (5) step(4'b0100);
    drain();
    // randomized traffic
    lat_cfg = -1;
    ext_busy_pct = 10;
    a = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) a[b] = ~a[b];
      step(a);
    end
    ext_busy_pct = 0;
    drain();
    check("queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
